// File: rtl/i2s_receiver_pkg.sv
// Shared audio definitions: sample/frame widths common to the audio input and
// output paths and the FIFO, plus the I2S receiver state encoding.
package i2s_receiver_pkg;

  localparam int unsigned AUDIO_SAMPLE_BITS = 24;
  localparam int unsigned AUDIO_FRAME_BITS  = 2 * AUDIO_SAMPLE_BITS;

  typedef enum logic [1:0] {
    RX_SYNC  = 2'd0,
    RX_LEFT  = 2'd1,
    RX_RIGHT = 2'd2
  } rx_state_e;

endpackage

// File: rtl/i2s_rx_sync.sv
// Brings the three asynchronous I2S pins into the clk domain.
// Ports:
//   clk, rst      system clock, async active-low reset
//   sclk_i        external bit clock
//   lrclk_i       external word select
//   sdata_i       external serial data
//   sample_evt_o  one-cycle pulse per sclk rising edge, SYNC_STAGES+1 clk after the pin
//   lrclk_s_o     lrclk captured at the sample event
//   sdata_s_o     sdata captured at the sample event
module i2s_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk_i,
  input  logic lrclk_i,
  input  logic sdata_i,
  output logic sample_evt_o,
  output logic lrclk_s_o,
  output logic sdata_s_o
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] lrclk_q;
  logic [SYNC_STAGES-1:0] sdata_q;
  logic                   sclk_prev_q;
  logic                   evt_q;
  logic                   lrclk_s_q;
  logic                   sdata_s_q;
  logic                   rise_c;

  // Rising edge seen at the synchronizer output.
  assign rise_c = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;

  // Synchronizer chains; lrclk/sdata latched on the same edge that fires the
  // event so all three carry identical delay.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q      <= '0;
      lrclk_q     <= '0;
      sdata_q     <= '0;
      sclk_prev_q <= 1'b0;
      evt_q       <= 1'b0;
      lrclk_s_q   <= 1'b0;
      sdata_s_q   <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
      lrclk_q     <= {lrclk_q[SYNC_STAGES-2:0], lrclk_i};
      sdata_q     <= {sdata_q[SYNC_STAGES-2:0], sdata_i};
      sclk_prev_q <= sclk_q[SYNC_STAGES-1];
      evt_q       <= rise_c;
      if (rise_c) begin
        lrclk_s_q <= lrclk_q[SYNC_STAGES-1];
        sdata_s_q <= sdata_q[SYNC_STAGES-1];
      end
    end
  end

  assign sample_evt_o = evt_q;
  assign lrclk_s_o    = lrclk_s_q;
  assign sdata_s_o    = sdata_s_q;

endmodule

// File: rtl/i2s_receiver.sv
// I2S slave receiver: deserializes left/right samples and emits one
// {left, right} word per stereo frame on a valid/ready interface.
// Ports:
//   clk, rst          system clock, async active-low reset
//   enable            receiver enable; low returns to SYNC and clears datapath
//   clear_overflow    pulse clearing overflow and short_slot
//   i2s_sclk/lrclk/sdata  asynchronous I2S pins
//   out_data          {left, right}
//   out_valid/ready   frame handshake
//   overflow          sticky: completed frame dropped
//   short_slot        sticky: slot ended with fewer than SAMPLE_BITS bits
module i2s_receiver
  import i2s_receiver_pkg::*;
#(
  parameter int unsigned SAMPLE_BITS = AUDIO_SAMPLE_BITS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clear_overflow,
  input  logic                     i2s_sclk,
  input  logic                     i2s_lrclk,
  input  logic                     i2s_sdata,
  output logic [2*SAMPLE_BITS-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overflow,
  output logic                     short_slot
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_BITS + 1);
  localparam int unsigned IDX_W = $clog2(SAMPLE_BITS);

  logic                     sample_evt;
  logic                     lrclk_s;
  logic                     sdata_s;

  rx_state_e                state_q;
  logic                     lr_prev_q;
  logic [CNT_W-1:0]         bit_cnt_q;
  logic [SAMPLE_BITS-1:0]   left_q;
  logic [SAMPLE_BITS-1:0]   right_q;
  logic [2*SAMPLE_BITS-1:0] out_data_q;
  logic                     out_valid_q;
  logic                     overflow_q;
  logic                     short_slot_q;

  logic                     transition_c;
  logic                     cnt_full_c;
  logic [IDX_W-1:0]         bit_idx_c;

  i2s_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk          (clk),
    .rst          (rst),
    .sclk_i       (i2s_sclk),
    .lrclk_i      (i2s_lrclk),
    .sdata_i      (i2s_sdata),
    .sample_evt_o (sample_evt),
    .lrclk_s_o    (lrclk_s),
    .sdata_s_o    (sdata_s)
  );

  // Slot boundary detection and MSB-first bit position.
  always_comb begin
    transition_c = (lrclk_s != lr_prev_q);
    cnt_full_c   = (bit_cnt_q >= CNT_W'(SAMPLE_BITS));
    bit_idx_c    = IDX_W'(SAMPLE_BITS - 1) - IDX_W'(bit_cnt_q);
  end

  // Receiver FSM with capture datapath, output handshake and sticky flags.
  // Later assignments win, so flag sets override a coincident clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RX_SYNC;
      lr_prev_q    <= 1'b0;
      bit_cnt_q    <= '0;
      left_q       <= '0;
      right_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      short_slot_q <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (clear_overflow) begin
        overflow_q   <= 1'b0;
        short_slot_q <= 1'b0;
      end
      // Track lrclk even while disabled so re-enable sees no stale edge.
      if (sample_evt) lr_prev_q <= lrclk_s;

      if (!enable) begin
        state_q     <= RX_SYNC;
        bit_cnt_q   <= '0;
        left_q      <= '0;
        right_q     <= '0;
        out_valid_q <= 1'b0;
      end else if (sample_evt) begin
        case (state_q)
          RX_SYNC: begin
            if (transition_c && !lrclk_s) begin
              state_q   <= RX_LEFT;
              left_q    <= '0;
              bit_cnt_q <= '0;
            end
          end
          RX_LEFT: begin
            if (transition_c) begin
              if (!cnt_full_c) short_slot_q <= 1'b1;
              state_q   <= RX_RIGHT;
              right_q   <= '0;
              bit_cnt_q <= '0;
            end else if (!cnt_full_c) begin
              left_q[bit_idx_c] <= sdata_s;
              bit_cnt_q         <= bit_cnt_q + CNT_W'(1);
            end
          end
          RX_RIGHT: begin
            if (transition_c) begin
              if (!cnt_full_c) short_slot_q <= 1'b1;
              state_q   <= RX_LEFT;
              left_q    <= '0;
              bit_cnt_q <= '0;
              // Accept if the output slot is empty or draining this cycle.
              if (!out_valid_q || out_ready) begin
                out_data_q  <= {left_q, right_q};
                out_valid_q <= 1'b1;
              end else begin
                overflow_q <= 1'b1;
              end
            end else if (!cnt_full_c) begin
              right_q[bit_idx_c] <= sdata_s;
              bit_cnt_q          <= bit_cnt_q + CNT_W'(1);
            end
          end
          default: state_q <= RX_SYNC;
        endcase
      end
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign overflow   = overflow_q;
  assign short_slot = short_slot_q;

endmodule
